// File: rtl/pmf_alu_pkg.sv
// rtl/pmf_alu_pkg.sv - op codes and sizing helper shared by the pmf ALU pipe
package pmf_alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  // Bits needed to hold any count in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pmf_alu_pipe_fifo.sv
// rtl/pmf_alu_pipe_fifo.sv - tagged result queue (pmf_result_fifo) feeding the CDB
module pmf_result_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] wr_ptr_q;
  logic [QW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Upstream credit accounting guarantees a push never lands on a full queue.
  assign do_push = push && !flush;
  assign do_pop  = pop && (count_q != '0) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + QW'(do_push) - QW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/pmf_alu_pipe.sv
// rtl/pmf_alu_pipe.sv - pipelined add/sub/and/or unit with credit-based CDB result queue
module pmf_alu_pipe
  import pmf_alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LABEL_W   = 4,
  parameter int STAGES    = 1,
  parameter int OUT_DEPTH = 2
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_op,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               flush,
  output logic               cdb_req,
  input  logic               cdb_ack,
  output logic [WIDTH-1:0]   cdb_data,
  output logic [LABEL_W-1:0] cdb_label,
  output logic               cdb_ovf,
  output logic               busy
);

  localparam int EW = WIDTH + LABEL_W + 1;
  localparam int CW = cnt_width(OUT_DEPTH + STAGES);
  localparam int QW = $clog2(OUT_DEPTH) + 1;

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("pmf_alu_pipe: STAGES must be in 1..4");
  end

  alu_op_e          op;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] res;
  logic             ovf;
  logic [EW-1:0]    comp_entry;
  logic [EW-1:0]    push_entry;
  logic [EW-1:0]    head;
  logic             push;
  logic             pop;
  logic [CW-1:0]    pipe_cnt;
  logic [QW-1:0]    q_count;
  logic             q_empty;

  assign op     = alu_op_e'(in_op);
  assign accept = in_valid && in_ready && !flush;

  // SUB shares the adder: a + ~b + 1, with overflow judged against ~b.
  always_comb begin
    b_eff = (op == ALU_SUB) ? ~in_b : in_b;
    sum   = in_a + b_eff + WIDTH'(op == ALU_SUB);
    res   = sum;
    ovf   = 1'b0;
    unique case (op)
      ALU_ADD, ALU_SUB: ovf = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      ALU_AND:          res = in_a & in_b;
      ALU_OR:           res = in_a | in_b;
    endcase
  end

  assign comp_entry = {ovf, in_label, res};

  if (STAGES == 1) begin : g_direct
    assign push       = accept;
    assign push_entry = comp_entry;
    assign pipe_cnt   = '0;
  end else begin : g_pipe
    localparam int PD = STAGES - 1;

    logic [PD-1:0] vld_q;
    logic [EW-1:0] ent_q [PD];

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        vld_q <= '0;
      end else if (flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        for (int i = 1; i < PD; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      ent_q[0] <= comp_entry;
      for (int i = 1; i < PD; i++) ent_q[i] <= ent_q[i-1];
    end

    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < PD; i++) pipe_cnt = pipe_cnt + CW'(vld_q[i]);
    end

    assign push       = vld_q[PD-1];
    assign push_entry = ent_q[PD-1];
  end

  pmf_result_fifo #(
    .W     (EW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (q_count),
    .empty     (q_empty)
  );

  // Credits cover both in-flight and queued ops, so the pipeline never has to stall.
  assign in_ready = (pipe_cnt + CW'(q_count)) < CW'(OUT_DEPTH);
  assign cdb_req  = !q_empty;
  assign pop      = cdb_req && cdb_ack;
  assign {cdb_ovf, cdb_label, cdb_data} = cdb_req ? head : '0;
  assign busy     = (pipe_cnt != '0) || (q_count != '0);

endmodule

// File: tb/tb_pmf_alu_pipe.sv
// tb/tb_pmf_alu_pipe.sv - self-checking bench for pmf_alu_pipe across three configurations
module tb_pmf_alu_pipe;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [3:0]  l;
    logic        o;
  } ent_t;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_label;
  logic        flush;
  logic        cdb_ack;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference arithmetic on true signed values; overflow means the result leaves 32-bit range.
  function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
    longint sa;
    longint sb;
    longint s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'd0;
    o  = 1'b0;
    case (op)
      OP_ADD: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_SUB: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      OP_AND: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    localparam int DP = (g == 2) ? 4 : 2;

    logic        rdy;
    logic        req;
    logic        ovf;
    logic        busy;
    logic [31:0] data;
    logic [3:0]  lab;

    pmf_alu_pipe #(
      .WIDTH     (32),
      .LABEL_W   (4),
      .STAGES    (ST),
      .OUT_DEPTH (DP)
    ) u_dut (
      .clk       (clk),
      .RST       (RST),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_label  (in_label),
      .flush     (flush),
      .cdb_req   (req),
      .cdb_ack   (cdb_ack),
      .cdb_data  (data),
      .cdb_label (lab),
      .cdb_ovf   (ovf),
      .busy      (busy)
    );

    ent_t pq[$];
    ent_t rq[$];
    int   cyc = 0;

    always @(posedge clk or posedge RST) begin : model
      int          n;
      bit          room;
      logic [31:0] r;
      logic        o;
      ent_t        e;
      if (RST) begin
        pq.delete();
        rq.delete();
        cyc = 0;
      end else begin
        n    = cyc;
        cyc  = cyc + 1;
        room = (pq.size() + rq.size()) < DP;
        if (flush) begin
          pq.delete();
          rq.delete();
        end else begin
          if (rq.size() != 0 && cdb_ack) void'(rq.pop_front());
          if (in_valid && room) begin
            ref_alu(in_op, in_a, in_b, r, o);
            e = '{due: n + ST - 1, d: r, l: in_label, o: o};
            pq.push_back(e);
          end
          while (pq.size() != 0 && pq[0].due <= n) rq.push_back(pq.pop_front());
        end
      end
    end

    always @(negedge clk) begin : compare
      bit any;
      any = rq.size() != 0;
      chk($sformatf("u%0d.in_ready", g), {63'd0, rdy}, {63'd0, (pq.size() + rq.size()) < DP});
      chk($sformatf("u%0d.busy", g), {63'd0, busy}, {63'd0, (pq.size() + rq.size()) != 0});
      chk($sformatf("u%0d.cdb_req", g), {63'd0, req}, {63'd0, any});
      chk($sformatf("u%0d.cdb_data", g), {32'd0, data}, any ? {32'd0, rq[0].d} : 64'd0);
      chk($sformatf("u%0d.cdb_label", g), {60'd0, lab}, any ? {60'd0, rq[0].l} : 64'd0);
      chk($sformatf("u%0d.cdb_ovf", g), {63'd0, ovf}, any ? {63'd0, rq[0].o} : 64'd0);
    end
  end

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] l, input logic ack, input logic fl);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_label = l;
    cdb_ack  = ack;
    flush    = fl;
  endtask

  task automatic drain(input int n);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    #1 RST = 1'b1;
    @(negedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("reset.in_ready", {63'd0, g_dut[0].rdy}, 64'd1);
    chk("reset.cdb_req", {63'd0, g_dut[1].req}, 64'd0);
    chk("reset.busy", {63'd0, g_dut[2].busy}, 64'd0);

    // Reset mid-burst with two results queued in the single-stage unit.
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 4'd1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'd3, 32'd4, 4'd2, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, OP_ADD, 32'd5, 32'd6, 4'd3, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("burst.cdb_req", {63'd0, g_dut[0].req}, 64'd1);
    chk("burst.cdb_data", {32'd0, g_dut[0].data}, 64'd3);
    chk("burst.in_ready", {63'd0, g_dut[0].rdy}, 64'd0);
    #2 RST = 1'b1;
    #1;
    chk("rst_async.cdb_req", {63'd0, g_dut[0].req}, 64'd0);
    chk("rst_async.cdb_data", {32'd0, g_dut[0].data}, 64'd0);
    chk("rst_async.cdb_label", {60'd0, g_dut[0].lab}, 64'd0);
    chk("rst_async.in_ready", {63'd0, g_dut[0].rdy}, 64'd1);
    chk("rst_async.busy", {63'd0, g_dut[0].busy}, 64'd0);
    @(negedge clk);
    RST = 1'b0;

    // Single-stage arithmetic with the CDB granting every cycle.
    drive(1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1, 1'b0);
    @(negedge clk);
    chk("add.cdb_req", {63'd0, g_dut[0].req}, 64'd1);
    chk("add.cdb_data", {32'd0, g_dut[0].data}, 64'd12);
    chk("add.cdb_label", {60'd0, g_dut[0].lab}, 64'd3);
    drive(1'b1, OP_SUB, 32'd3, 32'd5, 4'd4, 1'b1, 1'b0);
    @(negedge clk);
    chk("sub.cdb_data", {32'd0, g_dut[0].data}, 64'hFFFF_FFFE);
    chk("sub.cdb_ovf", {63'd0, g_dut[0].ovf}, 64'd0);
    drive(1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 4'd5, 1'b1, 1'b0);
    @(negedge clk);
    chk("or.cdb_data", {32'd0, g_dut[0].data}, 64'hFF);
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1, 4'd6, 1'b1, 1'b0);
    @(negedge clk);
    chk("add_ovf.cdb_data", {32'd0, g_dut[0].data}, 64'h8000_0000);
    chk("add_ovf.cdb_ovf", {63'd0, g_dut[0].ovf}, 64'd1);
    drive(1'b1, OP_SUB, 32'h8000_0000, 32'd1, 4'd7, 1'b1, 1'b0);
    @(negedge clk);
    chk("sub_ovf.cdb_data", {32'd0, g_dut[0].data}, 64'h7FFF_FFFF);
    chk("sub_ovf.cdb_ovf", {63'd0, g_dut[0].ovf}, 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle.cdb_req", {63'd0, g_dut[0].req}, 64'd0);
    drain(6);

    // Backpressure on the three-stage unit: only two of four ops fit.
    drive(1'b1, OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    in_label = 4'd9;
    @(negedge clk);
    chk("bp.in_ready_low", {63'd0, g_dut[1].rdy}, 64'd0);
    in_label = 4'd10;
    @(negedge clk);
    in_label = 4'd11;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.head_label", {60'd0, g_dut[1].lab}, 64'd8);
    chk("bp.head_data", {32'd0, g_dut[1].data}, 64'h0F00_0F00);
    @(negedge clk);
    chk("bp.still_blocked", {63'd0, g_dut[1].rdy}, 64'd0);
    cdb_ack = 1'b1;
    @(negedge clk);
    chk("bp.second_label", {60'd0, g_dut[1].lab}, 64'd9);
    chk("bp.in_ready_back", {63'd0, g_dut[1].rdy}, 64'd1);
    @(negedge clk);
    chk("bp.empty", {63'd0, g_dut[1].req}, 64'd0);
    drain(6);

    // Sustained one result per cycle with push and pop on the same edge.
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        chk($sformatf("stream%0d.cdb_label", i), {60'd0, g_dut[0].lab}, 64'(i - 1));
        chk($sformatf("stream%0d.cdb_req", i), {63'd0, g_dut[0].req}, 64'd1);
      end
      drive(1'b1, OP_ADD, 32'(i), 32'd100, 4'(i), 1'b1, 1'b0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_end.cdb_data", {32'd0, g_dut[0].data}, 64'd109);
    drain(6);

    // Flush with one op in flight, two queued, and a concurrent issue and grant.
    drive(1'b1, OP_OR, 32'h1, 32'h2, 4'd12, 1'b0, 1'b0);
    @(negedge clk);
    in_label = 4'd13;
    @(negedge clk);
    in_label = 4'd14;
    @(negedge clk);
    chk("fl.pre_label", {60'd0, g_dut[2].lab}, 64'd12);
    chk("fl.pre_busy", {63'd0, g_dut[2].busy}, 64'd1);
    drive(1'b1, OP_OR, 32'h1, 32'h2, 4'd15, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    chk("fl.busy", {63'd0, g_dut[2].busy}, 64'd0);
    chk("fl.cdb_req", {63'd0, g_dut[2].req}, 64'd0);
    chk("fl.in_ready", {63'd0, g_dut[2].rdy}, 64'd1);
    chk("fl.u1_busy", {63'd0, g_dut[1].busy}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("fl.quiet%0d", i), {63'd0, g_dut[2].req}, 64'd0);
    end

    // Mixed ops with an irregular grant pattern and a flush in the middle.
    for (int i = 0; i < 24; i++) begin
      drive((i % 5) != 4, 2'(i % 4), 32'(i) * 32'h1357_9BDF, 32'hFFFF_FFFF - 32'(i) * 32'h0246_8ACE,
            4'(i), (i % 3) != 0, i == 13);
      @(negedge clk);
    end
    drain(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
